// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock time base and its display block.
//   state_t  : run/stop state of the time base
//   *_MAX    : BCD limits of each digit pair (packed {tens, units})
//   bcd_inc  : one-step increment of a BCD digit pair with wrap at its limit
package clock_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HR_MAX   = 8'h23;
  localparam logic [3:0] UNIT_MAX = 4'h9;

  // Limit is checked first so 23 wraps to 00 before the units rule sees it.
  function automatic logic [7:0] bcd_inc(input logic [7:0] pair,
                                         input logic [7:0] max_pair);
    if (pair == max_pair) return 8'h00;
    if (pair[3:0] == UNIT_MAX) return {pair[7:4] + 4'd1, 4'd0};
    return {pair[7:4], pair[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/time_counter_if.sv
// Bus between the time base and its neighbours.
//   inputs  : freq (1 Hz square wave), start, stop, clr, inc_min, inc_hr pulses
//   outputs : six BCD digits, running, sec_tick, day_wrap
// master drives the control inputs and reads the digits; slave is the time base.
interface time_counter_if;
  logic       freq;
  logic       start;
  logic       stop;
  logic       clr;
  logic       inc_min;
  logic       inc_hr;
  logic [1:0] hh_t;
  logic [3:0] hh_u;
  logic [2:0] mm_t;
  logic [3:0] mm_u;
  logic [2:0] ss_t;
  logic [3:0] ss_u;
  logic       running;
  logic       sec_tick;
  logic       day_wrap;

  modport master (
    output freq, start, stop, clr, inc_min, inc_hr,
    input  hh_t, hh_u, mm_t, mm_u, ss_t, ss_u, running, sec_tick, day_wrap
  );

  modport slave (
    input  freq, start, stop, clr, inc_min, inc_hr,
    output hh_t, hh_u, mm_t, mm_u, ss_t, ss_u, running, sec_tick, day_wrap
  );
endinterface

// File: rtl/edge_sync.sv
// Multi-stage synchronizer followed by a rising-edge pulse generator.
//   ck    : clock
//   rst   : synchronous reset, active low
//   din   : asynchronous or slow level input
//   pulse : high for one cycle after a rising edge reaches the last stage
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic ck,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge ck) begin
    if (!rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign pulse = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/time_counter.sv
// 24-hour BCD time base driven by one rising edge of freq per second.
//   ck          : system clock
//   rst         : synchronous reset, active low
//   bus (slave) : freq and button pulses in; digits, running, sec_tick,
//                 day_wrap out (all registered)
//
// state | meaning
// STOP  | time held; inc_min / inc_hr adjust it; freq edges ignored
// RUN   | each freq edge advances one second; inc_* ignored
module time_counter
  import clock_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic          ck,
  input  logic          rst,
  time_counter_if.slave bus
);

  state_t     state;
  logic       running_q;
  logic       sec_tick_q;
  logic       day_wrap_q;
  logic [7:0] ss_q;
  logic [7:0] mm_q;
  logic [7:0] hh_q;
  logic       tick;

  logic sec_carry;
  logic min_carry;
  logic day_carry;

  edge_sync #(.STAGES(SYNC_STAGES)) u_freq_sync (
    .ck    (ck),
    .rst   (rst),
    .din   (bus.freq),
    .pulse (tick)
  );

  // Cascaded carry chain: each pair only advances when all lower pairs wrap.
  assign sec_carry = (ss_q == SEC_MAX);
  assign min_carry = sec_carry && (mm_q == MIN_MAX);
  assign day_carry = min_carry && (hh_q == HR_MAX);

  always_ff @(posedge ck) begin
    if (!rst) begin
      state      <= STOP;
      running_q  <= 1'b0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      ss_q       <= 8'h00;
      mm_q       <= 8'h00;
      hh_q       <= 8'h00;
    end else begin
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;

      // stop wins over a simultaneous start
      case (state)
        STOP: if (bus.start && !bus.stop) begin
          state     <= RUN;
          running_q <= 1'b1;
        end
        RUN: if (bus.stop) begin
          state     <= STOP;
          running_q <= 1'b0;
        end
      endcase

      // Decisions use the current state, so a tick with stop still counts
      // and a tick with start is dropped.
      if (bus.clr) begin
        ss_q <= 8'h00;
        mm_q <= 8'h00;
        hh_q <= 8'h00;
      end else if (state == RUN) begin
        if (tick) begin
          sec_tick_q <= 1'b1;
          day_wrap_q <= day_carry;
          ss_q       <= bcd_inc(ss_q, SEC_MAX);
          if (sec_carry) mm_q <= bcd_inc(mm_q, MIN_MAX);
          if (min_carry) hh_q <= bcd_inc(hh_q, HR_MAX);
        end
      end else begin
        if (bus.inc_min) begin
          mm_q <= bcd_inc(mm_q, MIN_MAX);
          ss_q <= 8'h00;
        end
        if (bus.inc_hr) hh_q <= bcd_inc(hh_q, HR_MAX);
      end
    end
  end

  assign bus.hh_t     = 2'(hh_q[7:4]);
  assign bus.hh_u     = hh_q[3:0];
  assign bus.mm_t     = 3'(mm_q[7:4]);
  assign bus.mm_u     = mm_q[3:0];
  assign bus.ss_t     = 3'(ss_q[7:4]);
  assign bus.ss_u     = ss_q[3:0];
  assign bus.running  = running_q;
  assign bus.sec_tick = sec_tick_q;
  assign bus.day_wrap = day_wrap_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with a seconds-of-day reference model.
module tb_time_counter;

  localparam int SYNC = 2;

  logic ck;
  logic rst;
  time_counter_if bus ();

  time_counter #(.SYNC_STAGES(SYNC)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int checks = 0;
  int errors = 0;

  // Reference model: time as seconds since midnight.
  int  m_secs = 0;
  bit  m_run = 0;
  bit  m_stick = 0;
  bit  m_wrap = 0;
  bit  m_valid = 0;
  bit  m_prev_f = 0;
  int  m_edge = 0;
  int  m_due[$];

  always @(posedge ck) begin
    int  h, m, s;
    bit  tick_now;
    m_edge++;
    if (!rst) begin
      m_secs = 0; m_run = 0; m_stick = 0; m_wrap = 0;
      m_prev_f = 0; m_due.delete(); m_valid = 1;
    end else begin
      if (bus.freq && !m_prev_f) m_due.push_back(m_edge + SYNC);
      m_prev_f = bus.freq;
      tick_now = 0;
      if (m_due.size() > 0 && m_due[0] == m_edge) begin
        tick_now = 1;
        void'(m_due.pop_front());
      end
      m_stick = 0; m_wrap = 0;
      if (bus.clr) m_secs = 0;
      else if (m_run) begin
        if (tick_now) begin
          m_stick = 1;
          m_wrap  = (m_secs == 86399);
          m_secs  = (m_secs + 1) % 86400;
        end
      end else begin
        h = m_secs / 3600; m = (m_secs / 60) % 60; s = m_secs % 60;
        if (bus.inc_min) begin m = (m + 1) % 60; s = 0; end
        if (bus.inc_hr) h = (h + 1) % 24;
        m_secs = h * 3600 + m * 60 + s;
      end
      if (bus.stop) m_run = 0;
      else if (bus.start) m_run = 1;
    end
  end

  function automatic logic [22:0] expect_vec(int secs, bit r, bit st, bit dw);
    int h, m, s;
    h = secs / 3600; m = (secs / 60) % 60; s = secs % 60;
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
            3'(s / 10), 4'(s % 10), r, st, dw};
  endfunction

  int stick_cnt = 0;
  int wrap_cnt = 0;

  always @(negedge ck) begin
    logic [22:0] act, exp_v;
    if (m_valid) begin
      act = {bus.hh_t, bus.hh_u, bus.mm_t, bus.mm_u, bus.ss_t, bus.ss_u,
             bus.running, bus.sec_tick, bus.day_wrap};
      exp_v = expect_vec(m_secs, m_run, m_stick, m_wrap);
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL cycle_compare t=%0t actual %h expected %h", $time, act, exp_v);
      end
      if (bus.sec_tick === 1'b1) stick_cnt++;
      if (bus.day_wrap === 1'b1) wrap_cnt++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic int dut_time();
    return (int'(bus.hh_t) * 10 + int'(bus.hh_u)) * 3600 +
           (int'(bus.mm_t) * 10 + int'(bus.mm_u)) * 60 +
           int'(bus.ss_t) * 10 + int'(bus.ss_u);
  endfunction

  task automatic pulse(input bit s, input bit p, input bit c, input bit im, input bit ih);
    bus.start = s; bus.stop = p; bus.clr = c; bus.inc_min = im; bus.inc_hr = ih;
    @(negedge ck);
    bus.start = 0; bus.stop = 0; bus.clr = 0; bus.inc_min = 0; bus.inc_hr = 0;
    @(negedge ck);
  endtask

  task automatic fperiod(input int n);
    repeat (n) begin
      bus.freq = 1; repeat (3) @(negedge ck);
      bus.freq = 0; repeat (3) @(negedge ck);
    end
  endtask

  int base;

  initial begin
    rst = 0;
    bus.freq = 0; bus.start = 0; bus.stop = 0; bus.clr = 0;
    bus.inc_min = 0; bus.inc_hr = 0;
    repeat (3) @(negedge ck);
    chk("reset_time", dut_time(), 0);
    chk("reset_running", int'(bus.running), 0);
    rst = 1;
    fperiod(3);
    chk("no_start_time", dut_time(), 0);
    chk("no_start_ticks", stick_cnt, 0);

    // 61 seconds
    pulse(1, 0, 0, 0, 0);
    chk("start_running", int'(bus.running), 1);
    base = stick_cnt;
    fperiod(61);
    chk("t61_time", dut_time(), 61);
    chk("t61_model", m_secs, 61);
    chk("t61_ticks", stick_cnt - base, 61);

    // preload 23:59:00 and roll over the day
    pulse(0, 1, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    repeat (23) pulse(0, 0, 0, 0, 1);
    repeat (59) pulse(0, 0, 0, 1, 0);
    chk("preload_time", dut_time(), 86340);
    pulse(1, 0, 0, 0, 0);
    base = stick_cnt;
    fperiod(60);
    chk("wrap_time", dut_time(), 0);
    chk("wrap_ticks", stick_cnt - base, 60);
    chk("wrap_count", wrap_cnt, 1);

    // inc_min at 00:59:05, inc_hr wrap, ignored in RUN
    pulse(0, 1, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    repeat (59) pulse(0, 0, 0, 1, 0);
    pulse(1, 0, 0, 0, 0);
    fperiod(5);
    pulse(0, 1, 0, 0, 0);
    chk("pre_incmin_time", dut_time(), 3545);
    pulse(0, 0, 0, 1, 0);
    chk("incmin_wrap_time", dut_time(), 0);
    repeat (23) pulse(0, 0, 0, 0, 1);
    chk("hr23_time", dut_time(), 82800);
    pulse(0, 0, 0, 1, 1);
    chk("hr_wrap_both_time", dut_time(), 60);
    pulse(0, 0, 1, 0, 0);
    pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 0);
    pulse(0, 0, 0, 0, 1);
    chk("run_inc_ignored", dut_time(), 0);

    // clr coincident with tick
    base = stick_cnt;
    bus.freq = 1;
    @(negedge ck); @(negedge ck);
    bus.clr = 1;
    @(negedge ck);
    bus.clr = 0;
    @(negedge ck);
    bus.freq = 0;
    repeat (3) @(negedge ck);
    chk("clr_tick_time", dut_time(), 0);
    chk("clr_tick_ticks", stick_cnt - base, 0);

    // start+stop together
    pulse(1, 1, 0, 0, 0);
    chk("startstop_run", int'(bus.running), 0);
    pulse(1, 1, 0, 0, 0);
    chk("startstop_stop", int'(bus.running), 0);

    // stop coincident with tick counts, then halts
    pulse(1, 0, 0, 0, 0);
    bus.freq = 1;
    @(negedge ck); @(negedge ck);
    bus.stop = 1;
    @(negedge ck);
    bus.stop = 0;
    @(negedge ck);
    bus.freq = 0;
    repeat (3) @(negedge ck);
    chk("stop_tick_time", dut_time(), 1);
    chk("stop_tick_running", int'(bus.running), 0);
    fperiod(2);
    chk("stopped_time", dut_time(), 1);

    // reset during a pending edge at 12:34:56
    pulse(0, 0, 1, 0, 0);
    repeat (12) pulse(0, 0, 0, 0, 1);
    repeat (34) pulse(0, 0, 0, 1, 0);
    pulse(1, 0, 0, 0, 0);
    fperiod(56);
    chk("pre_reset_time", dut_time(), 45296);
    base = stick_cnt;
    bus.freq = 1;
    @(negedge ck);
    rst = 0;
    @(negedge ck);
    rst = 1;
    chk("mid_reset_time", dut_time(), 0);
    chk("mid_reset_running", int'(bus.running), 0);
    @(negedge ck);
    bus.freq = 0;
    repeat (6) @(negedge ck);
    chk("mid_reset_ticks", stick_cnt - base, 0);
    chk("mid_reset_time_after", dut_time(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
